// File: rtl/theta_col_parity_unit.sv
// ---------------------------------------------------------------------------
// theta_col_parity_unit
//
// Column-parity (theta) step over a 5x5 lane state held in a single-port,
// 1-cycle-latency state memory. Responds to the encoder controller's
// start/ready handshake.
//
// Sequence: LOAD streams all 25 lanes and folds each lane into its column
// parity C[x]. DRAIN absorbs the last read, which is still in flight. CALC
// forms D[x] = C[x-1] ^ ROL1(C[x+1]), with indices taken mod 5. UPD_RD and
// UPD_WR then read-modify-write every lane with lane ^ D[x].
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; aborts any op in flight
//   start      start request, level-sampled while idle
//   ready      1 = idle/done, 0 = busy
//   mem_addr   lane address, 5*y + x
//   mem_rd_en  read strobe; mem_rdata is valid the following cycle
//   mem_rdata  read data from the state memory
//   mem_wr_en  write strobe
//   mem_wdata  write data; 0 whenever mem_wr_en = 0
//   state      current FSM state, for debug/trace
// ---------------------------------------------------------------------------
module theta_col_parity_unit #(
  parameter int LANE_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [LANE_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [LANE_W-1:0] mem_wdata,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DRAIN  = 3'd2,
    S_CALC   = 3'd3,
    S_UPD_RD = 3'd4,
    S_UPD_WR = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        x_q, x_d;
  logic [2:0]        y_q, y_d;
  logic [LANE_W-1:0] c_q [5];
  logic [LANE_W-1:0] d_q [5];
  // The read issued in LOAD returns one cycle later. These registers carry
  // that read's column index and validity so the fold lands in the right C[x].
  logic              ld_vld_q;
  logic [2:0]        ld_x_q;

  logic              last_lane;
  int                lane_idx;

  function automatic logic [LANE_W-1:0] rol1(input logic [LANE_W-1:0] v);
    return {v[LANE_W-2:0], v[LANE_W-1]};
  endfunction

  assign last_lane = (x_q == 3'd4) && (y_q == 3'd4);

  // Next-state and counter logic.
  // NOTE: every signal written in an always_comb is given a default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          x_d     = 3'd0;
          y_d     = 3'd0;
        end
      end
      S_LOAD, S_UPD_WR: begin
        // Raster order: x is the fast index, and the counters wrap to 0
        // after lane 24.
        if (x_q == 3'd4) begin
          x_d = 3'd0;
          y_d = (y_q == 3'd4) ? 3'd0 : y_q + 3'd1;
        end else begin
          x_d = x_q + 3'd1;
        end
        if (last_lane) state_d = (state_q == S_LOAD) ? S_DRAIN : S_IDLE;
        else if (state_q == S_UPD_WR) state_d = S_UPD_RD;
      end
      S_DRAIN:  state_d = S_CALC;
      S_CALC: begin
        state_d = S_UPD_RD;
        x_d     = 3'd0;
        y_d     = 3'd0;
      end
      S_UPD_RD: state_d = S_UPD_WR;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples pre-edge values, whatever the order of the
  // statements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= 3'd0;
      y_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Parity and mask storage.
  // NOTE: the small C/D register arrays are reset explicitly, because the
  // reset state is defined as all-zero. Large RAMs would not be reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_vld_q <= 1'b0;
      ld_x_q   <= 3'd0;
      for (int i = 0; i < 5; i++) begin
        c_q[i] <= '0;
        d_q[i] <= '0;
      end
    end else begin
      ld_vld_q <= (state_q == S_LOAD);
      ld_x_q   <= x_q;
      if (state_q == S_IDLE && start) begin
        for (int i = 0; i < 5; i++) c_q[i] <= '0;
      end else if (ld_vld_q) begin
        c_q[ld_x_q] <= c_q[ld_x_q] ^ mem_rdata;
      end
      if (state_q == S_CALC) begin
        for (int i = 0; i < 5; i++) d_q[i] <= c_q[(i + 4) % 5] ^ rol1(c_q[(i + 1) % 5]);
      end
    end
  end

  // Moore outputs. Only mem_wdata looks at mem_rdata, and it does so only
  // in UPD_WR, where the read issued in UPD_RD has returned.
  always_comb begin
    lane_idx  = 5 * int'(y_q) + int'(x_q);
    mem_addr  = ADDR_W'(lane_idx);
    ready     = (state_q == S_IDLE);
    mem_rd_en = (state_q == S_LOAD) || (state_q == S_UPD_RD);
    mem_wr_en = (state_q == S_UPD_WR);
    mem_wdata = mem_wr_en ? (mem_rdata ^ d_q[x_q]) : '0;
    state     = state_q;
  end

endmodule

// File: tb/tb_theta_col_parity_unit.sv
// ---------------------------------------------------------------------------
// tb_theta_col_parity_unit
//
// Drives theta_col_parity_unit against a behavioural state memory. Checks
// the handshake timing, the access sequence and the final memory contents.
// Expected contents come from a plain software theta on a 25-lane image.
// ---------------------------------------------------------------------------
module tb_theta_col_parity_unit;

  localparam int LANE_W = 64;
  localparam int ADDR_W = 5;
  localparam logic [63:0] MSB = 64'h8000_0000_0000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [LANE_W-1:0] mem_rdata;
  logic              mem_wr_en;
  logic [LANE_W-1:0] mem_wdata;
  logic [2:0]        state;

  theta_col_parity_unit #(.LANE_W(LANE_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ready     (ready),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .state     (state)
  );

  always #5 clk = ~clk;

  // State memory: registered read, write on edge. The backdoor port
  // preloads the memory while the DUT is idle.
  logic [63:0] mem [32];
  logic        bd_we = 1'b0;
  logic [4:0]  bd_addr = '0;
  logic [63:0] bd_data = '0;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  // Access monitor.
  int rd_log[$];
  int wr_log[$];
  int conflicts = 0;
  int wdata_viol = 0;
  int oob = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en) rd_log.push_back(int'(mem_addr));
      if (mem_wr_en) wr_log.push_back(int'(mem_addr));
      if (mem_rd_en && mem_wr_en) conflicts++;
      if (!mem_wr_en && mem_wdata != '0) wdata_viol++;
      if ((mem_rd_en || mem_wr_en) && mem_addr > 5'd24) oob++;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: theta written directly from the column-parity rules.
  logic [63:0] img [25];
  logic [63:0] exp_lane [25];

  function automatic logic [63:0] rotl1(input logic [63:0] v);
    return (v << 1) | (v >> 63);
  endfunction

  task automatic theta_ref();
    logic [63:0] col [5];
    for (int x = 0; x < 5; x++) begin
      col[x] = '0;
      for (int y = 0; y < 5; y++) col[x] = col[x] ^ img[5*y + x];
    end
    for (int i = 0; i < 25; i++)
      exp_lane[i] = img[i] ^ col[(i % 5 + 4) % 5] ^ rotl1(col[(i % 5 + 1) % 5]);
  endtask

  task automatic bd_write(input int a, input logic [63:0] d);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_addr = 5'(a);
    bd_data = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic load_img();
    for (int i = 0; i < 25; i++) bd_write(i, img[i]);
    for (int i = 25; i < 32; i++) bd_write(i, 64'hDEAD_BEEF_0000_0000 | 64'(i));
  endtask

  // Runs one op and checks handshake timing, access order and the result.
  // poke >= 0 raises start for one cycle at that busy cycle.
  task automatic run_op(input string name, input int poke);
    int  rd_base, wr_base, conf_base, viol_base, oob_base, cycles;
    bit  order_ok, sent_ok;
    theta_ref();
    rd_base   = rd_log.size();
    wr_base   = wr_log.size();
    conf_base = conflicts;
    viol_base = wdata_viol;
    oob_base  = oob;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({name, " ready_fall"}, 64'(ready), 64'd0);
    check({name, " state_load"}, 64'(state), 64'd1);
    cycles = 0;
    while (!ready && cycles < 200) begin
      @(posedge clk);
      #1 cycles++;
      start = (cycles == poke);
    end
    start = 1'b0;
    check({name, " busy_cycles"}, 64'(cycles), 64'd77);
    check({name, " reads"}, 64'(rd_log.size() - rd_base), 64'd50);
    check({name, " writes"}, 64'(wr_log.size() - wr_base), 64'd25);
    order_ok = (rd_log.size() - rd_base == 50) && (wr_log.size() - wr_base == 25);
    if (order_ok)
      for (int i = 0; i < 25; i++)
        if (rd_log[rd_base+i] != i || rd_log[rd_base+25+i] != i || wr_log[wr_base+i] != i)
          order_ok = 1'b0;
    check({name, " addr_order"}, 64'(order_ok), 64'd1);
    check({name, " rd_wr_conflict"}, 64'(conflicts - conf_base), 64'd0);
    check({name, " wdata_idle_zero"}, 64'(wdata_viol - viol_base), 64'd0);
    check({name, " out_of_range"}, 64'(oob - oob_base), 64'd0);
    for (int i = 0; i < 25; i++) check($sformatf("%s lane%0d", name, i), mem[i], exp_lane[i]);
    sent_ok = 1'b1;
    for (int i = 25; i < 32; i++)
      if (mem[i] !== (64'hDEAD_BEEF_0000_0000 | 64'(i))) sent_ok = 1'b0;
    check({name, " high_addr_untouched"}, 64'(sent_ok), 64'd1);
  endtask

  initial begin
    int base;
    // Reset state, sampled while reset is held.
    #12;
    check("reset ready", 64'(ready), 64'd1);
    check("reset rd_en", 64'(mem_rd_en), 64'd0);
    check("reset wr_en", 64'(mem_wr_en), 64'd0);
    check("reset state", 64'(state), 64'd0);
    check("reset addr", 64'(mem_addr), 64'd0);
    check("reset wdata", 64'(mem_wdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // All-zero state: the memory must come back unchanged.
    for (int i = 0; i < 25; i++) img[i] = '0;
    load_img();
    run_op("zero", -1);

    // Single bit in lane 0.
    for (int i = 0; i < 25; i++) img[i] = '0;
    img[0] = 64'h1;
    load_img();
    run_op("lane0", -1);
    check("lane0 const l1", mem[1], 64'h1);
    check("lane0 const l4", mem[4], 64'h2);

    // MSB in lane 1 exercises the rotate wrap.
    for (int i = 0; i < 25; i++) img[i] = '0;
    img[1] = MSB;
    load_img();
    run_op("wrap", -1);
    check("wrap const l5", mem[5], 64'h1);
    check("wrap const l22", mem[22], MSB);

    // Random state, with start pulsed mid-update: the pulse must be ignored.
    for (int i = 0; i < 25; i++) img[i] = {$urandom, $urandom};
    load_img();
    run_op("poke", 40);
    base = rd_log.size();
    repeat (10) @(posedge clk);
    #1 check("poke no_second_op", 64'(rd_log.size() - base), 64'd0);
    check("poke ready_stays", 64'(ready), 64'd1);

    // Async reset mid-op, then a fresh op on the partially updated memory.
    for (int i = 0; i < 25; i++) img[i] = {$urandom, $urandom};
    load_img();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort ready", 64'(ready), 64'd1);
    check("abort state", 64'(state), 64'd0);
    check("abort rd_en", 64'(mem_rd_en), 64'd0);
    check("abort wr_en", 64'(mem_wr_en), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) img[i] = mem[i];
    run_op("after_abort", -1);

    // Several more random states.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 25; i++) img[i] = {$urandom, $urandom};
      load_img();
      run_op($sformatf("rand%0d", t), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
